// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tst2in_seq.sv
// Self-test sequencer for two-input cells: walks {A2,A1} through a 9-code
// single-bit-transition sequence and checks ZN against a parameterised truth table.
module gf180mcu_fd_sc_mcu9t5v0__tst2in_seq #(
    parameter logic [3:0]  TRUTH  = 4'b0001,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERRW   = 8
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    input  logic            ZN,
    output logic            A1,
    output logic            A2,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [ERRW-1:0] ERRCNT,
    output logic [3:0]      FAIL_VEC
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [3:0] LAST_IDX  = 4'd8;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [3:0]      fvec_q, fvec_d;
    logic            mism;

    // Walk order {A2,A1}: 00,01,11,10,00,10,11,01,00 - each step flips one pin.
    function automatic logic [1:0] walk_code(input logic [3:0] i);
        case (i)
            4'd0:    walk_code = 2'b00;
            4'd1:    walk_code = 2'b01;
            4'd2:    walk_code = 2'b11;
            4'd3:    walk_code = 2'b10;
            4'd4:    walk_code = 2'b00;
            4'd5:    walk_code = 2'b10;
            4'd6:    walk_code = 2'b11;
            4'd7:    walk_code = 2'b01;
            default: walk_code = 2'b00;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
        end
    end

    // Case-inequality so an X/Z from the cell under test is flagged as a miss.
    assign mism = (ZN !== TRUTH[code_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE: begin
                code_d = 2'b00;
                if (START) begin
                    code_d  = walk_code(4'd0);
                    idx_d   = '0;
                    cnt_d   = SETTLE_M1;
                    err_d   = '0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mism) begin
                    if (err_q != {ERRW{1'b1}}) begin
                        err_d = err_q + ERRW'(1);
                    end
                    fvec_d[code_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    code_d  = walk_code(idx_q + 4'd1);
                    cnt_d   = SETTLE_M1;
                    state_d = S_WAIT;
                end
            end
            S_FIN: begin
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_FIN);
    end

    assign A1       = code_q[0];
    assign A2       = code_q[1];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERRCNT   = err_q;
    assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__tst2in_seq.sv
// Scoreboard bench: two sequencers (ERRW=8 with a selectable cell model, ERRW=3 fixed OR model).
module tb_gf180mcu_fd_sc_mcu9t5v0__tst2in_seq;

    localparam logic [1:0] M_NOR = 2'd0, M_ST1 = 2'd1, M_ST0 = 2'd2, M_OR = 2'd3;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       zn, zn3;
    logic       a1, a2, busy, done, pass;
    logic [7:0] errcnt;
    logic [3:0] fvec;
    logic       a1b, a2b, busyb, doneb, passb;
    logic [2:0] errcntb;
    logic [3:0] fvecb;

    logic [1:0] zn_mode = M_NOR;
    logic       xinj = 1'b0;
    int         edge_cnt = 0;
    int         e0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Expected entry: {done_at[15:0], pass, errcnt[7:0], fail_vec[3:0]}
    logic [28:0] exp_q[$];
    logic [28:0] exp3_q[$];
    logic [1:0]  code_q[$];
    logic [1:0]  walk_tbl [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    always_comb begin
        case (zn_mode)
            M_NOR:   zn = ~(a1 | a2);
            M_ST1:   zn = 1'b1;
            M_ST0:   zn = 1'b0;
            default: zn = a1 | a2;
        endcase
        if (xinj) zn = 1'bx;
    end
    assign zn3 = a1b | a2b;

    gf180mcu_fd_sc_mcu9t5v0__tst2in_seq u_dut (
        .CLK(CLK), .RN(RN), .START(START), .ZN(zn),
        .A1(a1), .A2(a2), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERRCNT(errcnt), .FAIL_VEC(fvec)
    );

    gf180mcu_fd_sc_mcu9t5v0__tst2in_seq #(.ERRW(3)) u_dut3 (
        .CLK(CLK), .RN(RN), .START(START), .ZN(zn3),
        .A1(a1b), .A2(a2b), .BUSY(busyb), .DONE(doneb), .PASS(passb),
        .ERRCNT(errcntb), .FAIL_VEC(fvecb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor, main instance
    always begin
        logic [28:0] e;
        @(negedge CLK);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_at", edge_cnt, {16'd0, e[28:13]});
                check("busy_low_in_fin", {31'd0, busy}, 32'd0);
                check("errcnt", {24'd0, errcnt}, {24'd0, e[11:4]});
                check("fail_vec", {28'd0, fvec}, {28'd0, e[3:0]});
                @(negedge CLK);
                check("pass", {31'd0, pass}, {31'd0, e[12]});
            end
        end
    end

    // Result monitor, ERRW=3 instance
    always begin
        logic [28:0] e;
        @(negedge CLK);
        if (doneb) begin
            if (exp3_q.size() == 0) begin
                check("unexpected_done_w3", 32'd1, 32'd0);
            end else begin
                e = exp3_q.pop_front();
                check("done_at_w3", edge_cnt, {16'd0, e[28:13]});
                check("errcnt_w3", {29'd0, errcntb}, {24'd0, e[11:4]});
                check("fail_vec_w3", {28'd0, fvecb}, {28'd0, e[3:0]});
                @(negedge CLK);
                check("pass_w3", {31'd0, passb}, {31'd0, e[12]});
            end
        end
    end

    // Walk monitor: each newly presented code while busy is matched against the expected walk
    always begin
        logic       busy_d1;
        logic [1:0] code_d1;
        busy_d1 = 1'b0;
        code_d1 = 2'b00;
        forever begin
            @(negedge CLK);
            if (busy && (!busy_d1 || {a2, a1} != code_d1)) begin
                if (code_q.size() == 0) check("unexpected_code", 32'd1, 32'd0);
                else check("walk_code", {30'd0, a2, a1}, {30'd0, code_q.pop_front()});
            end
            busy_d1 = busy;
            code_d1 = {a2, a1};
        end
    end

    task automatic push_run(input int at, input logic [7:0] ec, input logic [3:0] fv);
        exp_q.push_back({16'(at), (ec == 8'd0), ec, fv});
        exp3_q.push_back({16'(at), 1'b0, 8'd7, 4'b1111});
        for (int k = 0; k < 9; k++) code_q.push_back(walk_tbl[k]);
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [7:0] ec, input logic [3:0] fv);
        zn_mode = mode;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        e0 = edge_cnt;
        check("cleared_on_start", {20'd0, busy, pass, fvec, errcnt}, {20'd0, 1'b1, 1'b0, 4'd0, 8'd0});
        push_run(e0 + 27, ec, fv);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && exp3_q.size() == 0) break;
            @(negedge CLK);
        end
        check("run_completes", exp_q.size() + exp3_q.size(), 32'd0);
        exp_q.delete();
        exp3_q.delete();
        repeat (3) @(negedge CLK);
        check("walk_consumed", code_q.size(), 32'd0);
        code_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outputs", {16'd0, a1, a2, busy, done, pass, errcnt, fvec}, 32'd0);
        RN = 1'b1;
        repeat (2) @(negedge CLK);

        start_run(M_NOR, 8'd0, 4'b0000);
        wait_done();
        start_run(M_ST1, 8'd6, 4'b1110);
        wait_done();
        start_run(M_ST0, 8'd3, 4'b0001);
        wait_done();
        start_run(M_OR, 8'd9, 4'b1111);
        wait_done();

        // START re-pulse mid-run is ignored; X on ZN during the code-4 (00) check counts once
        start_run(M_NOR, 8'd1, 4'b0001);
        repeat (11) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        xinj = 1'b1;
        @(negedge CLK);
        xinj = 1'b0;
        wait_done();

        start_run(M_NOR, 8'd0, 4'b0000);
        wait_done();

        // START held high: second run accepted after one IDLE cycle
        zn_mode = M_ST0;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        e0 = edge_cnt;
        push_run(e0 + 27, 8'd3, 4'b0001);
        push_run(e0 + 56, 8'd3, 4'b0001);
        repeat (31) @(negedge CLK);
        START = 1'b0;
        wait_done();

        start_run(M_NOR, 8'd0, 4'b0000);
        wait_done();

        // Reset mid-run: asynchronous clear, no DONE afterwards
        start_run(M_NOR, 8'd0, 4'b0000);
        repeat (13) @(negedge CLK);
        #2;
        RN = 1'b0;
        exp_q.delete();
        exp3_q.delete();
        code_q.delete();
        #1;
        check("async_reset_outputs", {16'd0, a1, a2, busy, done, pass, errcnt, fvec}, 32'd0);
        check("async_reset_w3", {20'd0, a1b, a2b, busyb, doneb, passb, errcntb, fvecb}, 32'd0);
        repeat (2) @(negedge CLK);
        RN = 1'b1;
        repeat (40) @(negedge CLK);
        check("idle_after_reset", {30'd0, busy, done}, 32'd0);

        start_run(M_NOR, 8'd0, 4'b0000);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__tst2in_seq.md
# gf180mcu_fd_sc_mcu9t5v0__tst2in_seq

Self-test sequencer for two-input combinational cells in the 9-track 5 V library, such as the nor2 family. It drives the cell's A1/A2 pins through a fixed walk that covers every single-input transition in both directions and samples ZN after a programmable settle time. Each sample is checked against a parameterised truth table, and the block reports a pass flag, an error count and a per-code fail vector. It sits on the driving side of a cell under test in characterisation and silicon-monitor harnesses.

## Interface
- TRUTH, 4'b0001: expected ZN indexed by {A2,A1}. The default is NOR: 1 only at code 00.
- SETTLE, 2: cycles A1/A2 are held before ZN is sampled. Legal range is 1..15; 0 is illegal.
- ERRW, 8: width of the error counter.

- CLK  input  1  clock; all state changes on the rising edge.
- RN  input  1  reset; asynchronous, active-low.
- START  input  1  request a test run; sampled only in IDLE.
- ZN  input  1  output of the cell under test. It is combinational from A1/A2 and in the CLK domain.
- A1  output  1  registered stimulus to the cell's A1 pin.
- A2  output  1  registered stimulus to the cell's A2 pin.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse at the end of a run.
- PASS  output  1  1 when the last completed run had zero mismatches.
- ERRCNT  output  ERRW  mismatch count for the current or last run.
- FAIL_VEC  output  4  bit i is set if any check at code {A2,A1}=i mismatched.

## Operation
- Walk of 9 codes ({A2,A1}), index 0..8: 00,01,11,10,00,10,11,01,00. Consecutive codes differ in exactly one bit.
- States:
  - IDLE: A1=A2=0. On START=1, load code[0], clear ERRCNT, FAIL_VEC and PASS, zero the step index, then go to WAIT.
  - WAIT: hold the code for SETTLE cycles, using a down-counter loaded with SETTLE-1. Go to CHECK when the counter reaches 0.
  - CHECK: compare ZN against TRUTH[{A2,A1}] using a case-inequality compare, so X or Z on ZN counts as a mismatch. On mismatch, increment ERRCNT and set FAIL_VEC[{A2,A1}]. If index==8, go to FIN. Otherwise increment the index, load the next code onto A1/A2 and go to WAIT.
  - FIN: DONE=1 for this one cycle, PASS=(ERRCNT==0), then go to IDLE.
- ERRCNT saturates at 2^ERRW-1 and never wraps. FAIL_VEC still updates after saturation.
- Results (PASS, ERRCNT, FAIL_VEC) hold after FIN until the next accepted START.
- START outside IDLE (in WAIT, CHECK or FIN) is ignored. It is neither queued nor restarts the run.
- START held high continuously starts a new run on each return to IDLE, i.e. back-to-back runs with one IDLE cycle between them.
- Reset asserted at any time, including mid-run:
  - all registers return to reset values immediately;
  - the run is abandoned with no DONE pulse;
  - after reset the block is in IDLE.

## Timing
- Reset values: A1=0, A2=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAIL_VEC=0, state IDLE.
- The START accept edge is E0. From E0+1 cycle onward, A1/A2 show code[0] and BUSY=1.
- Each code is held for SETTLE+1 cycles: SETTLE in WAIT plus 1 in CHECK. ZN is sampled at the rising edge that ends the CHECK cycle.
- ERRCNT and FAIL_VEC update on that same edge. A1/A2 change to the next code on that edge too.
- DONE=1 and BUSY=0 in the cycle starting at E0+9·(SETTLE+1). With SETTLE=2 that is E0+27. PASS is valid from the following cycle.
- BUSY is high exactly in WAIT and CHECK. DONE is high exactly in FIN. They are never high together.
- All outputs are registered. There is no combinational path from ZN or START to any output.

## Test plan
- Ideal NOR model on ZN, default parameters, START pulse: DONE at E0+27, PASS=1, ERRCNT=0, FAIL_VEC=0000. The A1/A2 trace matches the 9-code walk.
- ZN stuck-at-1: ERRCNT=6, FAIL_VEC=1110, PASS=0.
- ZN stuck-at-0: ERRCNT=3, FAIL_VEC=0001, PASS=0.
- OR model (ZN inverted) with ERRW=3: all 9 checks mismatch, ERRCNT saturates at 7, FAIL_VEC=1111, PASS=0.
- START re-pulsed at E0+10, then ZN=X for one CHECK cycle:
  - the run is not restarted and DONE still occurs at E0+27;
  - the X check counts as one mismatch;
  - a second START clears the results before the next run.
- RN pulled low at E0+12 during a run: all outputs go to reset values asynchronously and no DONE pulse occurs. A fresh run with the NOR model then passes.
